instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 73 +++++++
 tb/tb_instr_fetch_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives a sequential fetch PC to instruction memory and
// buffers returned words with their addresses in a small FIFO for decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] PC_addr_o,
    input  logic [31:0] instr_i,
    input  logic        hit_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [31:0]   r_mem_instr [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign PC_addr_o     = r_pc;
    assign instr_valid_o = (r_count != '0);
    assign instr_o       = instr_valid_o ? r_mem_instr[r_rd_ptr] : '0;
    assign instr_pc_o    = instr_valid_o ? r_mem_pc[r_rd_ptr]    : '0;

    // A full buffer still accepts a fetch when the head leaves in the same cycle.
    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = instr_valid_o && instr_ready_i;
    assign w_push = hit_i && !redirect_i && (!w_full || w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_i) begin
            r_pc     <= {redirect_addr_i[31:2], 2'b00};
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_pc[r_wr_ptr]    <= r_pc;
                r_mem_instr[r_wr_ptr] <= instr_i;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
                r_pc                  <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus short random bench for instr_fetch_unit; a queue of expected
// {pc, instr} pairs is filled on modelled pushes and drained on pops.
module tb_instr_fetch_unit;

    localparam logic [31:0] K_INSTR = 32'h5A5A_C3C3;
    localparam int unsigned TB_DEPTH = 2;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] PC_addr_o;
    logic [31:0] instr_i;
    logic        hit_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb [$];
    logic [31:0] mpc;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (TB_DEPTH)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .PC_addr_o       (PC_addr_o),
        .instr_i         (instr_i),
        .hit_i           (hit_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o)
    );

    // Memory model: the word returned for an address is a fixed function of it.
    assign instr_i = PC_addr_o ^ K_INSTR;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic hit, input logic ready,
                        input logic redir, input logic [31:0] raddr);
        logic pop;
        logic push;
        rst_i           = rst;
        hit_i           = hit;
        instr_ready_i   = ready;
        redirect_i      = redir;
        redirect_addr_i = raddr;
        #3;
        chk("pc", PC_addr_o, mpc);
        chk("valid", {31'd0, instr_valid_o}, {31'd0, (sb.size() != 0)});
        if (sb.size() != 0) begin
            chk("instr", instr_o, sb[0][31:0]);
            chk("ipc", instr_pc_o, sb[0][63:32]);
        end else begin
            chk("instr0", instr_o, 32'd0);
            chk("ipc0", instr_pc_o, 32'd0);
        end
        if (rst) begin
            sb.delete();
            mpc = 32'h0000_0000;
        end else if (redir) begin
            sb.delete();
            mpc = {raddr[31:2], 2'b00};
        end else begin
            pop  = (sb.size() != 0) && ready;
            push = hit && ((sb.size() < TB_DEPTH) || pop);
            if (pop) void'(sb.pop_front());
            if (push) begin
                sb.push_back({mpc, mpc ^ K_INSTR});
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i           = 1'b1;
        hit_i           = 1'b1;
        instr_ready_i   = 1'b1;
        redirect_i      = 1'b1;
        redirect_addr_i = 32'h0000_0040;
        mpc             = 32'h0000_0000;
        repeat (2) @(posedge clk_i);
        #1;

        // Continuous streaming from reset
        repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

        // Back-pressure from a fresh reset: fills, holds at 8, then drains in order
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

        // Head stays stable while stalled, no fetch without hit
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

        // Redirect with a full buffer, unaligned target
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

        // Address wrap at the top of the space
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

        // Reset with a full buffer and active hit
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

        // Random traffic with occasional redirects
        for (int i = 0; i < 60; i++) begin
            step(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
